// File: rtl/serial_subtractor.sv
// Bit-serial a - b - borrowin, LSB first, one result bit per clock, start/done handshake.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrowin,
  output logic [WIDTH-1:0] diff,
  output logic             borrowout,
  output logic             busy,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             ovf,
`endif
  output logic             done
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d, bo_q, bo_d, busy_q, busy_d, done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             a0, b0, d_bit, br_nx;

  assign a0    = a_q[0];
  assign b0    = b_q[0];
  assign d_bit = a0 ^ b0 ^ br_q;
  assign br_nx = (~a0 & b0) | (~(a0 ^ b0) & br_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bo_d    = bo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SHIFT;
        a_d     = a;
        b_d     = b;
        br_d    = borrowin;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
      SHIFT: begin
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = br_nx;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          // Signed overflow: borrow into the MSB differs from borrow out of it.
          ovf_d   = br_q ^ br_nx;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        bo_d    = br_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign diff      = diff_q;
  assign borrowout = bo_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf       = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge monitor pops on done.
module tb_serial_subtractor;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         borrowin = 1'b0;
  logic [W-1:0] diff;
  logic         borrowout, busy, done;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .borrowin(borrowin),
    .diff(diff), .borrowout(borrowout), .busy(busy),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf(ovf),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] d; logic bo; logic ov; } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, n_done = 0, n_push = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      n_done++;
      if (q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        check("diff", 32'(diff), 32'(e.d));
        check("borrowout", 32'(borrowout), 32'(e.bo));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check("ovf", 32'(ovf), 32'(e.ov));
`endif
      end
    end
  end

  task automatic push(input logic [W-1:0] d, input logic bo, input logic ov);
    exp_t e;
    e.d = d; e.bo = bo; e.ov = ov;
    q.push_back(e);
    n_push++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
    #1;
  endtask

  // Issue one op, check busy and latency; returns after done is seen (or timeout).
  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bin,
                    input logic [W-1:0] d, input logic bo, input logic ov);
    int t, nd0;
    @(negedge clk);
    a = av; b = bv; borrowin = bin; start = 1'b1;
    push(d, bo, ov);
    nd0 = n_done;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_after_start", 32'(busy), 1);
    t = 0;
    while (n_done == nd0 && t < 20) begin
      @(negedge clk); #1; t++;
    end
    if (n_done == nd0) check("done_timeout", 0, 1);
    else check("latency", t, W + 1);
    check("busy_after_done", 32'(busy), 0);
  endtask

  initial begin
    int t, nd0, c1, c2;
    #1;
    check("rst_diff", 32'(diff), 0);
    check("rst_bo", 32'(borrowout), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    @(negedge clk); rst_n = 1'b1;

    op(4'h9, 4'h3, 1'b0, 4'h6, 1'b0, 1'b1);
    op(4'h3, 4'h9, 1'b0, 4'hA, 1'b1, 1'b1);
    op(4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0);
    op(4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
    op(4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1);
    op(4'h5, 4'h2, 1'b0, 4'h3, 1'b0, 1'b0);
    op(4'h0, 4'h1, 1'b0, 4'hF, 1'b1, 1'b0);
    op(4'hF, 4'h0, 1'b1, 4'hE, 1'b0, 1'b0);
    op(4'hA, 4'h5, 1'b1, 4'h4, 1'b0, 1'b1);

    // Start while busy is ignored; later operand changes have no effect.
    @(negedge clk);
    a = 4'h9; b = 4'h3; borrowin = 1'b0; start = 1'b1;
    push(4'h6, 1'b0, 1'b1);
    nd0 = n_done;
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 4'h1; b = 4'h1; borrowin = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    t = 0;
    while (n_done == nd0 && t < 20) begin @(negedge clk); #1; t++; end
    if (n_done == nd0) check("busy_start_timeout", 0, 1);
    idle(10);
    check("no_second_done", n_done, nd0 + 1);

    // Reset mid-operation aborts with no done.
    @(negedge clk);
    a = 4'h9; b = 4'h3; borrowin = 1'b0; start = 1'b1;
    nd0 = n_done;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_diff", 32'(diff), 0);
    check("abort_bo", 32'(borrowout), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    idle(10);
    check("abort_no_done", n_done, nd0);
    op(4'h7, 4'h2, 1'b0, 4'h5, 1'b0, 1'b0);

    // start held high: back-to-back every W+2 cycles.
    @(negedge clk);
    a = 4'h5; b = 4'h2; borrowin = 1'b0; start = 1'b1;
    push(4'h3, 1'b0, 1'b0);
    push(4'h3, 1'b0, 1'b0);
    nd0 = n_done; c1 = 0; c2 = 0; t = 0;
    while (n_done < nd0 + 2 && t < 40) begin
      @(negedge clk); #1; t++;
      if (n_done == nd0 + 1 && c1 == 0) c1 = cyc;
    end
    start = 1'b0;
    c2 = cyc;
    if (n_done < nd0 + 2) check("b2b_timeout", 0, 1);
    else check("b2b_gap", c2 - c1, W + 2);
    idle(12);

    check("done_count", n_done, n_push);
    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
